fifo_arbiter: RTL and testbench
===============================

# fifo_arbiter

Access arbiter and sequencer for the 8-entry FIFO. It shares the FIFO between two write requesters and one read requester. It issues at most one `fifo_wr_en` or `fifo_rd_en` per cycle, never both, so the FIFO never sees the undefined simultaneous read/write case. It tracks occupancy locally to refuse writes when full and reads when empty, and it reports refusals as write/read error pulses that match the FIFO's WR_ERROR and RD_ERROR semantics.

## Interface
- `DEPTH`, 8: FIFO entry count.
- `DW`, 32: data width.
- `CW`, 4: occupancy counter width; must hold the value DEPTH.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_req0`, `wr_req1`  in  1  write requests, level-sensitive.
- `wr_data0`, `wr_data1`  in  DW  write data, sampled with the matching request.
- `rd_req`  in  1  read request, level-sensitive.
- `wr_gnt0`, `wr_gnt1`, `rd_gnt`  out  1  one-cycle grant pulses, registered.
- `fifo_wr_en`, `fifo_rd_en`  out  1  FIFO strobes, registered, mutually exclusive.
- `fifo_din`  out  DW  FIFO write data, registered.
- `occupancy`  out  CW  entries held, range 0..DEPTH.
- `full`, `empty`  out  1  `full` = (occupancy==DEPTH); `empty` = (occupancy==0).
- `wr_err`, `rd_err`  out  1  one-cycle refusal pulses, registered.

## Operation
- Requesters W0, W1 and R are evaluated at every rising edge.
- Mask: a requester whose grant is high in the current cycle is ineligible at that edge. Without this, a held request would be granted twice.
- Eligibility:
  - W0 eligible = `wr_req0` & unmasked & occ<DEPTH.
  - W1 eligible = `wr_req1` & unmasked & occ<DEPTH.
  - R eligible = `rd_req` & unmasked & occ>0.
- Round-robin head pointer, states HEAD_W0, HEAD_W1, HEAD_R; reset value HEAD_W0.
  - The search order starts at the head: W0→W1→R→W0.
  - The first eligible requester is granted.
- Head update:
  - After a W0 grant, head becomes HEAD_W1.
  - After a W1 grant, head becomes HEAD_R.
  - After an R grant, head becomes HEAD_W0.
  - With no grant, head is unchanged.
- On a write grant: assert the matching `wr_gntN` and `fifo_wr_en`, set `fifo_din` = the sampled `wr_dataN`, and increment occupancy.
- On a read grant: assert `rd_gnt` and `fifo_rd_en`, and decrement occupancy.
- No grant: all grants and enables are 0, and `fifo_din` holds its last value.
- `wr_err` = 1 when any unmasked write request is sampled with occ==DEPTH. This is independent of whether a read is granted the same edge.
- `rd_err` = 1 when an unmasked `rd_req` is sampled with occ==0. This is independent of whether a write is granted.
- Occupancy never wraps. A single grant per edge keeps it within 0..DEPTH.
- Full with both R and W pending: R is the only eligible requester and is granted, taking occ to DEPTH-1. A write is granted at a later edge.
- Empty with both R and W pending: a write is granted and `rd_err` pulses.

## Timing
- Reset values:
  - All grants, `fifo_wr_en`, `fifo_rd_en`, `wr_err`, `rd_err` = 0.
  - `fifo_din` = 0; `occupancy` = 0; `full` = 0; `empty` = 1; head = HEAD_W0.
- Reset mid-operation: the next cycle shows the reset values, and any pending grant is dropped. The FIFO must share the same `reset`.
- Latency: request sampled at edge n. Grant, strobe, `fifo_din` and the new occupancy are all visible in the cycle after edge n.
- Handshake: a requester drops its request in the cycle its grant is high. A request still high after that cycle is a new request.
- Throughput:
  - Aggregate: one FIFO operation per cycle.
  - A single continuously requesting source: one grant every 2 cycles, because of the mask.
- `full` and `empty` are derived from the occupancy register only, so they are glitch-free.

## Test plan
1. Reset held for 2 cycles, then released with no requests → all outputs at reset values, `empty`=1, `occupancy`=0.
2. `wr_req0`=1 for one cycle with `wr_data0`=32'hA5A5A5A5 → next cycle: `wr_gnt0`=1, `fifo_wr_en`=1, `fifo_din`=32'hA5A5A5A5, `occupancy`=1.
3. From empty, `wr_req0` and `wr_req1` held high → grants alternate W0,W1,W0,… one per cycle.
   - After 8 grants: `full`=1, `occupancy`=8.
   - The next cycle: `wr_err`=1 and no `fifo_wr_en`.
4. At full with `wr_req0`=1 and `rd_req`=1 held → `rd_gnt` fires first (occ 8→7) with `wr_err`=1, then `wr_gnt0` fires (occ 7→8).
5. At empty with `rd_req`=1 for one cycle → next cycle `rd_err`=1, `fifo_rd_en`=0, `occupancy` remains 0.
6. From occ=4 with all three requests held → grant order W0,W1,R,W0. Occupancy goes 5,6,5,6, and `fifo_wr_en` and `fifo_rd_en` are never high together.
   - Assert `reset` after this sequence → next cycle `occupancy`=0 and head restarts at W0.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Round-robin access arbiter for a shared 8-entry FIFO: two writers, one reader,
// at most one FIFO strobe per cycle, local occupancy tracking with refusal pulses.
module fifo_arbiter #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req0,
  input  logic          wr_req1,
  input  logic [DW-1:0] wr_data0,
  input  logic [DW-1:0] wr_data1,
  input  logic          rd_req,
  output logic          wr_gnt0,
  output logic          wr_gnt1,
  output logic          rd_gnt,
  output logic          fifo_wr_en,
  output logic          fifo_rd_en,
  output logic [DW-1:0] fifo_din,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty,
  output logic          wr_err,
  output logic          rd_err,
  output logic [1:0]    head_state
);

  // Handshake: a request is a level held by the requester; the matching grant is a
  // one-cycle registered pulse, and the requester drops its request in that cycle.
  // A request still high in the grant cycle is masked, so it is never granted twice.

  typedef enum logic [1:0] {
    HEAD_W0 = 2'd0,
    HEAD_W1 = 2'd1,
    HEAD_R  = 2'd2
  } head_t;

  head_t head_q, head_d;

  logic elig_w0, elig_w1, elig_r;
  logic sel_w0, sel_w1, sel_r;
  logic wr_err_d, rd_err_d;

  assign full       = (occupancy == CW'(DEPTH));
  assign empty      = (occupancy == '0);
  assign head_state = head_q;

  assign elig_w0 = wr_req0 & ~wr_gnt0 & ~full;
  assign elig_w1 = wr_req1 & ~wr_gnt1 & ~full;
  assign elig_r  = rd_req  & ~rd_gnt  & ~empty;

  // Refusals look only at unmasked requests against the current occupancy.
  assign wr_err_d = ((wr_req0 & ~wr_gnt0) | (wr_req1 & ~wr_gnt1)) & full;
  assign rd_err_d = rd_req & ~rd_gnt & empty;

  always_comb begin
    sel_w0 = 1'b0;
    sel_w1 = 1'b0;
    sel_r  = 1'b0;
    head_d = head_q;
    case (head_q)
      HEAD_W0: begin
        if (elig_w0)      sel_w0 = 1'b1;
        else if (elig_w1) sel_w1 = 1'b1;
        else if (elig_r)  sel_r  = 1'b1;
      end
      HEAD_W1: begin
        if (elig_w1)      sel_w1 = 1'b1;
        else if (elig_r)  sel_r  = 1'b1;
        else if (elig_w0) sel_w0 = 1'b1;
      end
      default: begin
        if (elig_r)       sel_r  = 1'b1;
        else if (elig_w0) sel_w0 = 1'b1;
        else if (elig_w1) sel_w1 = 1'b1;
      end
    endcase
    if (sel_w0)      head_d = HEAD_W1;
    else if (sel_w1) head_d = HEAD_R;
    else if (sel_r)  head_d = HEAD_W0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= HEAD_W0;
      wr_gnt0    <= 1'b0;
      wr_gnt1    <= 1'b0;
      rd_gnt     <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_din   <= '0;
      occupancy  <= '0;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      head_q     <= head_d;
      wr_gnt0    <= sel_w0;
      wr_gnt1    <= sel_w1;
      rd_gnt     <= sel_r;
      fifo_wr_en <= sel_w0 | sel_w1;
      fifo_rd_en <= sel_r;
      wr_err     <= wr_err_d;
      rd_err     <= rd_err_d;
      if (sel_w0) fifo_din <= wr_data0;
      else if (sel_w1) fifo_din <= wr_data1;
      if (sel_w0 | sel_w1) occupancy <= occupancy + CW'(1);
      else if (sel_r) occupancy <= occupancy - CW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: reset, single write, fill, full/empty corners,
// round-robin order and mid-operation reset.
module tb_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0;
  logic [31:0] wr_data0 = '0, wr_data1 = '0;
  logic        wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en;
  logic [31:0] fifo_din;
  logic [3:0]  occupancy;
  logic        full, empty, wr_err, rd_err;
  logic [1:0]  head_state;

  int vectors = 0;
  int miscompares = 0;

  // {wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en, wr_err, rd_err, full, empty}
  logic [8:0] st;
  assign st = {wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en, wr_err, rd_err, full, empty};

  fifo_arbiter #(.DEPTH(8), .DW(32), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .wr_req0(wr_req0), .wr_req1(wr_req1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rd_req(rd_req),
    .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1), .rd_gnt(rd_gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_din(fifo_din), .occupancy(occupancy),
    .full(full), .empty(empty),
    .wr_err(wr_err), .rd_err(rd_err),
    .head_state(head_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_req0 = 0; wr_req1 = 0; rd_req = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (st !== 9'b000000001) begin
      miscompares++; $display("FAIL reset_flags got=%b exp=%b", st, 9'b000000001);
    end
    vectors++;
    if (occupancy !== 4'd0 || fifo_din !== 32'd0 || head_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_regs got occ=%0d din=%h head=%0d exp 0/0/0", occupancy, fifo_din, head_state);
    end
  endtask

  task automatic test_single_write();
    wr_req0 = 1; wr_data0 = 32'hA5A5A5A5;
    tick();
    wr_req0 = 0;
    vectors++;
    if (st !== 9'b100100000 || occupancy !== 4'd1 || fifo_din !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL single_write got st=%b occ=%0d din=%h exp st=100100000 occ=1 din=a5a5a5a5",
               st, occupancy, fifo_din);
    end
    wr_data0 = 32'h0;
    tick();
    vectors++;
    if (st !== 9'b000000000 || occupancy !== 4'd1 || fifo_din !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL idle_hold got st=%b occ=%0d din=%h exp st=000000000 occ=1 din=a5a5a5a5",
               st, occupancy, fifo_din);
    end
  endtask

  task automatic test_fill();
    logic [8:0]  exp_st;
    logic [31:0] exp_din;
    do_reset();
    wr_data0 = 32'h1000_0000; wr_data1 = 32'h2000_0000;
    wr_req0 = 1; wr_req1 = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_st  = {(i % 2 == 0), (i % 2 == 1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 7), 1'b0};
      exp_din = (i % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000;
      vectors++;
      if (st !== exp_st || occupancy !== 4'(i + 1) || fifo_din !== exp_din) begin
        miscompares++;
        $display("FAIL fill_%0d got st=%b occ=%0d din=%h exp st=%b occ=%0d din=%h",
                 i, st, occupancy, fifo_din, exp_st, i + 1, exp_din);
      end
    end
    tick();
    vectors++;
    if (st !== 9'b000001010 || occupancy !== 4'd8) begin
      miscompares++;
      $display("FAIL full_wr_err got st=%b occ=%0d exp st=000001010 occ=8", st, occupancy);
    end
  endtask

  task automatic test_full_read_write();
    wr_req1 = 0; wr_req0 = 1; rd_req = 1; wr_data0 = 32'hCAFE0004;
    tick();
    vectors++;
    if (st !== 9'b001011000 || occupancy !== 4'd7) begin
      miscompares++;
      $display("FAIL full_rd_first got st=%b occ=%0d exp st=001011000 occ=7", st, occupancy);
    end
    tick();
    wr_req0 = 0; rd_req = 0;
    vectors++;
    if (st !== 9'b100100010 || occupancy !== 4'd8 || fifo_din !== 32'hCAFE0004) begin
      miscompares++;
      $display("FAIL full_wr_next got st=%b occ=%0d din=%h exp st=100100010 occ=8 din=cafe0004",
               st, occupancy, fifo_din);
    end
    tick();
    vectors++;
    if (st !== 9'b000000010 || occupancy !== 4'd8) begin
      miscompares++;
      $display("FAIL full_idle got st=%b occ=%0d exp st=000000010 occ=8", st, occupancy);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_req = 1;
    tick();
    rd_req = 0;
    vectors++;
    if (st !== 9'b000000101 || occupancy !== 4'd0) begin
      miscompares++;
      $display("FAIL empty_rd_err got st=%b occ=%0d exp st=000000101 occ=0", st, occupancy);
    end
    tick();
    vectors++;
    if (st !== 9'b000000001) begin
      miscompares++; $display("FAIL empty_idle got st=%b exp st=000000001", st);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_seq [4];
    logic [3:0] occ_seq [4];
    exp_seq = '{9'b100100000, 9'b010100000, 9'b001010000, 9'b100100000};
    occ_seq = '{4'd5, 4'd6, 4'd5, 4'd6};
    do_reset();
    wr_req0 = 1; wr_req1 = 1;
    repeat (5) tick();
    wr_req0 = 0; wr_req1 = 0; rd_req = 1;
    tick();
    rd_req = 0;
    vectors++;
    if (rd_gnt !== 1'b1 || occupancy !== 4'd4) begin
      miscompares++;
      $display("FAIL rr_setup got rd_gnt=%b occ=%0d exp rd_gnt=1 occ=4", rd_gnt, occupancy);
    end
    tick();
    wr_req0 = 1; wr_req1 = 1; rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (st !== exp_seq[i] || occupancy !== occ_seq[i] || (fifo_wr_en & fifo_rd_en)) begin
        miscompares++;
        $display("FAIL rr_step_%0d got st=%b occ=%0d exp st=%b occ=%0d",
                 i, st, occupancy, exp_seq[i], occ_seq[i]);
      end
    end
    do_reset();
    #0;
    vectors++;
    if (st !== 9'b000000001 || occupancy !== 4'd0 || head_state !== 2'd0) begin
      miscompares++;
      $display("FAIL rr_reset got st=%b occ=%0d head=%0d exp st=000000001 occ=0 head=0",
               st, occupancy, head_state);
    end
    wr_req0 = 1; wr_req1 = 1; rd_req = 1; wr_data0 = 32'h0000_BEEF;
    tick();
    wr_req0 = 0; wr_req1 = 0; rd_req = 0;
    vectors++;
    if (st !== 9'b100100100 || occupancy !== 4'd1 || fifo_din !== 32'h0000_BEEF) begin
      miscompares++;
      $display("FAIL rr_restart got st=%b occ=%0d din=%h exp st=100100100 occ=1 din=0000beef",
               st, occupancy, fifo_din);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_full_read_write();
    test_empty_read();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
